// File: rtl/tetris_pkg.sv
// Shared PS/2 scancode constants, key indices and state types for the Tetris input path.
// Pure declarations: no latency, no backpressure.
package tetris_pkg;

   localparam logic [7:0] SC_E0    = 8'hE0;
   localparam logic [7:0] SC_F0    = 8'hF0;
   localparam logic [7:0] SC_LEFT  = 8'h6B;
   localparam logic [7:0] SC_RIGHT = 8'h74;
   localparam logic [7:0] SC_DOWN  = 8'h72;
   localparam logic [7:0] SC_UP    = 8'h75;
   localparam logic [7:0] SC_SPACE = 8'h29;
   localparam logic [7:0] SC_R     = 8'h2D;

   localparam int KEY_LEFT    = 0;
   localparam int KEY_RIGHT   = 1;
   localparam int KEY_DOWN    = 2;
   localparam int KEY_ROTATE  = 3;
   localparam int KEY_DROP    = 4;
   localparam int KEY_RESTART = 5;
   localparam int NUM_KEYS    = 6;

   typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
   typedef enum logic [1:0] {DEC_WAIT, DEC_E0, DEC_F0, DEC_E0F0} dec_state_t;

   typedef struct packed {
      logic       ext;
      logic       brk;
      logic [7:0] code;
   } sc_entry_t;

   // One-hot key hit; arrows only count with the E0 prefix, space/R only without it.
   function automatic logic [NUM_KEYS-1:0] key_match(input logic ext, input logic [7:0] code);
      key_match = '0;
      if (ext) begin
         case (code)
            SC_LEFT:  key_match[KEY_LEFT]   = 1'b1;
            SC_RIGHT: key_match[KEY_RIGHT]  = 1'b1;
            SC_DOWN:  key_match[KEY_DOWN]   = 1'b1;
            SC_UP:    key_match[KEY_ROTATE] = 1'b1;
            default:  key_match = '0;
         endcase
      end else begin
         case (code)
            SC_SPACE: key_match[KEY_DROP]    = 1'b1;
            SC_R:     key_match[KEY_RESTART] = 1'b1;
            default:  key_match = '0;
         endcase
      end
   endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 receiver: pin synchronisers, falling-edge detect, 11-bit deframer with odd parity check.
// rx_valid/rx_err one cycle after the stop edge; no backpressure; PS2_WATCHDOG_EN adds a stall abort.
module ps2_rx
   import tetris_pkg::*;
#(
   parameter int SYNC_STAGES = 2
`ifdef PS2_WATCHDOG_EN
   ,
   parameter int TIMEOUT_CYC = 50000
`endif
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] rx_byte,
   output logic       rx_valid,
   output logic       rx_err,
   output logic       rx_abort
);

   logic [SYNC_STAGES-1:0] clk_sync;
   logic [SYNC_STAGES-1:0] data_sync;
   logic                   clk_prev;
   logic                   fall;
   logic                   bit_in;
   logic                   wd_expire;

   rx_state_t  state;
   logic [2:0] bit_cnt;
   logic [7:0] shift;
   logic       par;

   // Idle-high reset values keep a released bus from looking like a falling edge.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         clk_sync  <= '1;
         data_sync <= '1;
         clk_prev  <= 1'b1;
      end else begin
         clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
         data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
         clk_prev  <= clk_sync[SYNC_STAGES-1];
      end
   end

   assign fall   = clk_prev & ~clk_sync[SYNC_STAGES-1];
   assign bit_in = data_sync[SYNC_STAGES-1];

`ifdef PS2_WATCHDOG_EN
   localparam int WD_W = $clog2(TIMEOUT_CYC);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);
   logic [WD_W-1:0] wd_cnt;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         wd_cnt <= '0;
      else if (fall || state == RX_IDLE || wd_expire)
         wd_cnt <= '0;
      else
         wd_cnt <= wd_cnt + 1'b1;
   end

   assign wd_expire = (state != RX_IDLE) && !fall && (wd_cnt == WD_LAST);
`else
   assign wd_expire = 1'b0;
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state    <= RX_IDLE;
         bit_cnt  <= '0;
         shift    <= '0;
         par      <= 1'b0;
         rx_valid <= 1'b0;
         rx_err   <= 1'b0;
         rx_abort <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         rx_err   <= 1'b0;
         rx_abort <= 1'b0;
         if (fall) begin
            case (state)
               RX_IDLE: begin
                  if (!bit_in) begin
                     state   <= RX_DATA;
                     bit_cnt <= '0;
                  end
               end
               RX_DATA: begin
                  shift   <= {bit_in, shift[7:1]};
                  bit_cnt <= bit_cnt + 1'b1;
                  if (bit_cnt == 3'd7)
                     state <= RX_PARITY;
               end
               RX_PARITY: begin
                  par   <= bit_in;
                  state <= RX_STOP;
               end
               RX_STOP: begin
                  state <= RX_IDLE;
                  if (bit_in && (^{shift, par}))
                     rx_valid <= 1'b1;
                  else
                     rx_err <= 1'b1;
               end
               default: state <= RX_IDLE;
            endcase
         end else if (wd_expire) begin
            state    <= RX_IDLE;
            rx_err   <= 1'b1;
            rx_abort <= 1'b1;
         end
      end
   end

   assign rx_byte = shift;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard front end: make/break/E0 decode, 3-entry scancode history, Tetris move pulses and held flags.
// Key pulse 2 cycles after the stop-edge detect; no backpressure; PS2_WATCHDOG_EN enables the stall watchdog.
module ps2_key_decoder
   import tetris_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT_CYC = 50000
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                ps2_clk,
   input  logic                ps2_data,
   output logic [29:0]         scancode,
   output logic                key_left,
   output logic                key_right,
   output logic                key_down,
   output logic                key_rotate,
   output logic                key_drop,
   output logic                key_restart,
   output logic [NUM_KEYS-1:0] key_held,
   output logic                frame_err
);

   if (SYNC_STAGES < 2 || TIMEOUT_CYC < 2) begin : g_param_check
      $error("ps2_key_decoder: SYNC_STAGES and TIMEOUT_CYC must both be >= 2");
   end

   logic [7:0] rx_byte;
   logic       rx_valid;
   logic       rx_err;
   logic       rx_abort;

   ps2_rx #(
      .SYNC_STAGES(SYNC_STAGES)
`ifdef PS2_WATCHDOG_EN
      ,
      .TIMEOUT_CYC(TIMEOUT_CYC)
`endif
   ) u_rx (
      .clock    (clock),
      .reset    (reset),
      .ps2_clk  (ps2_clk),
      .ps2_data (ps2_data),
      .rx_byte  (rx_byte),
      .rx_valid (rx_valid),
      .rx_err   (rx_err),
      .rx_abort (rx_abort)
   );

   dec_state_t          state;
   logic [NUM_KEYS-1:0] key_pulse;
   logic                cur_ext;
   logic                cur_brk;
   logic [NUM_KEYS-1:0] hit;
   sc_entry_t           entry;

   assign cur_ext = (state == DEC_E0) || (state == DEC_E0F0);
   assign cur_brk = (state == DEC_F0) || (state == DEC_E0F0);
   assign hit     = key_match(cur_ext, rx_byte);
   assign entry   = '{ext: cur_ext, brk: cur_brk, code: rx_byte};

   // E0 and F0 accumulate in either order; a repeat of a prefix already seen changes nothing.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= DEC_WAIT;
         scancode  <= '0;
         key_pulse <= '0;
         key_held  <= '0;
      end else begin
         key_pulse <= '0;
         if (rx_abort) begin
            state <= DEC_WAIT;
         end else if (rx_valid) begin
            if (rx_byte == SC_E0) begin
               state <= cur_brk ? DEC_E0F0 : DEC_E0;
            end else if (rx_byte == SC_F0) begin
               state <= cur_ext ? DEC_E0F0 : DEC_F0;
            end else begin
               state    <= DEC_WAIT;
               scancode <= {scancode[19:0], entry};
               if (cur_brk) begin
                  key_held <= key_held & ~hit;
               end else begin
                  key_pulse <= hit;
                  key_held  <= key_held | hit;
               end
            end
         end
      end
   end

   assign key_left    = key_pulse[KEY_LEFT];
   assign key_right   = key_pulse[KEY_RIGHT];
   assign key_down    = key_pulse[KEY_DOWN];
   assign key_rotate  = key_pulse[KEY_ROTATE];
   assign key_drop    = key_pulse[KEY_DROP];
   assign key_restart = key_pulse[KEY_RESTART];
   assign frame_err   = rx_err;

endmodule
